// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU in the EX stage.
// Stalls the pipeline while iterating and presents remainder on hi_o and quotient on lo_o.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic        annul,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        stall_o,
   output logic        ready,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_reg, state_next;
   logic [32:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] dvsr_reg;
   logic [31:0] dvnd_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic [5:0]  cnt_reg;

   logic        accept;
   logic        last_iter;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [33:0] shifted, trial;
   logic        q_bit;
   logic [32:0] rem_new;
   logic [31:0] quo_new;
   logic [31:0] q_fix, r_fix;

   assign accept    = (state_reg == IDLE) & start & ~annul;
   assign last_iter = (state_reg == BUSY) & (cnt_reg == 6'd31) & ~annul;
   assign stall_o   = accept | (state_reg == BUSY);

   // Operand magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
   always_comb begin
      a_neg = signed_div & a[31];
      b_neg = signed_div & b[31];
      a_mag = a_neg ? (~a + 32'd1) : a;
      b_mag = b_neg ? (~b + 32'd1) : b;
   end

   always_comb begin
      shifted = {rem_reg, quo_reg[31]};
      trial   = shifted - {2'b00, dvsr_reg};
      q_bit   = ~trial[33];
      rem_new = q_bit ? trial[32:0] : shifted[32:0];
      quo_new = {quo_reg[30:0], q_bit};
      q_fix   = neg_q_reg ? (~quo_new + 32'd1) : quo_new;
      r_fix   = neg_r_reg ? (~rem_new[31:0] + 32'd1) : rem_new[31:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (cnt_reg == 6'd31) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (annul) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvsr_reg  <= '0;
         dvnd_reg  <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         cnt_reg   <= '0;
         ready     <= 1'b0;
         hi_o      <= '0;
         lo_o      <= '0;
      end else begin
         ready <= last_iter;
         if (accept) begin
            rem_reg   <= '0;
            quo_reg   <= a_mag;
            dvsr_reg  <= b_mag;
            dvnd_reg  <= a;
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            cnt_reg   <= '0;
         end else if (state_reg == BUSY) begin
            rem_reg <= rem_new;
            quo_reg <= quo_new;
            cnt_reg <= cnt_reg + 6'd1;
         end
         // Divide by zero iterates normally but reports the raw dividend and an all-ones quotient.
         if (last_iter) begin
            if (dvsr_reg == 32'd0) begin
               hi_o <= dvnd_reg;
               lo_o <= 32'hFFFF_FFFF;
            end else begin
               hi_o <= r_fix;
               lo_o <= q_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases from the plan plus randomized
// divides with annul, all compared every cycle against a behavioural reference.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        stall_o;
   logic        ready;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_checks = 0;
   int n_fail   = 0;

   div_unit dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
      .a(a), .b(b), .stall_o(stall_o), .ready(ready), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result {hi, lo} computed with plain wide arithmetic.
   function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit sg);
      logic signed [63:0] sx, sy, q, r;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (sg) begin
         sx = {{32{x[31]}}, x};
         sy = {{32{y[31]}}, y};
         q  = sx / sy;
         r  = sx % sy;
         return {r[31:0], q[31:0]};
      end
      return {x % y, x / y};
   endfunction

   // Cycle model: an accepted divide occupies 32 busy cycles, then one result cycle.
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [63:0] m_res  = '0;
   logic        e_ready = 1'b0;
   logic [31:0] e_hi = '0, e_lo = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left  <= 0;
         m_done  <= 1'b0;
         e_ready <= 1'b0;
         e_hi    <= '0;
         e_lo    <= '0;
      end else begin
         e_ready <= 1'b0;
         m_done  <= 1'b0;
         if (m_left == 0 && !m_done) begin
            if (start && !annul) begin
               m_left <= 32;
               m_res  <= ref_div(a, b, signed_div);
            end
         end else if (m_left > 0) begin
            if (annul) m_left <= 0;
            else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  e_ready <= 1'b1;
                  m_done  <= 1'b1;
                  e_hi    <= m_res[63:32];
                  e_lo    <= m_res[31:0];
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic e_stall;
      e_stall = (m_left == 0 && !m_done && start && !annul) || (m_left > 0);
      chk("stall_o", {31'd0, stall_o}, {31'd0, e_stall});
      chk("ready",   {31'd0, ready},   {31'd0, e_ready});
      chk("hi_o", hi_o, e_hi);
      chk("lo_o", lo_o, e_lo);
   end

   // Presents one divide from posedge+2 and returns at posedge+2 of the cycle after ready.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit sg, input bit hold,
                        output int stall_cnt, output int lat);
      bit got;
      a = ta; b = tb_v; signed_div = sg; annul = 1'b0; start = 1'b1;
      stall_cnt = 0; lat = 0; got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stall_o) stall_cnt++;
         if (ready) begin got = 1'b1; break; end
         lat++;
         @(posedge clk); #2;
         if (!hold) start = 1'b0;
      end
      chk("ready_seen", {31'd0, got}, 32'd1);
      @(posedge clk); #2;
      if (!hold) start = 1'b0;
   endtask

   task automatic directed(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                           input bit sg, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int sc, lt;
      do_op(ta, tb_v, sg, 1'b0, sc, lt);
      chk({name, "_lo"}, lo_o, exp_lo);
      chk({name, "_hi"}, hi_o, exp_hi);
      chk({name, "_lat"}, lt, 32'd33);
   endtask

   initial begin
      int sc, lt, rdy_cnt;
      logic [31:0] save_hi, save_lo;
      logic [63:0] r;

      // Pin the reference model with hand-computed values.
      r = ref_div(32'd100, 32'd7, 1'b0);         chk("ref_100_7", r[31:0], 32'd14);
      r = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);   chk("ref_m7_2", r[63:32], 32'hFFFF_FFFF);
      r = ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); chk("ref_ovf", r[31:0], 32'h8000_0000);
      r = ref_div(32'd5, 32'd0, 1'b0);           chk("ref_dz", r[63:32], 32'd5);

      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);

      do_op(32'd100, 32'd7, 1'b0, 1'b0, sc, lt);
      chk("divu_100_7_lo", lo_o, 32'd14);
      chk("divu_100_7_hi", hi_o, 32'd2);
      chk("divu_100_7_stall", sc, 32'd33);
      chk("divu_100_7_lat", lt, 32'd33);

      directed("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      directed("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
      directed("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
      directed("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
      directed("divu_dz", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);

      // Annul in the 10th busy cycle.
      save_hi = hi_o; save_lo = lo_o;
      a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (9) begin @(posedge clk); #2; end
      annul = 1'b1;
      @(posedge clk); #2 annul = 1'b0;
      @(negedge clk);
      chk("annul_stall", {31'd0, stall_o}, 32'd0);
      rdy_cnt = 0;
      repeat (40) begin @(negedge clk); if (ready) rdy_cnt++; end
      chk("annul_no_ready", rdy_cnt, 32'd0);
      chk("annul_hi_kept", hi_o, save_hi);
      chk("annul_lo_kept", lo_o, save_lo);

      // Reset in the middle of a divide.
      @(posedge clk); #2;
      a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (5) begin @(posedge clk); #2; end
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, ready}, 32'd0);
      chk("mid_rst_hi", hi_o, 32'd0);
      chk("mid_rst_lo", lo_o, 32'd0);
      chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      directed("divu_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

      // Start held through the result cycle, then a back-to-back divide.
      do_op(32'd100, 32'd7, 1'b0, 1'b1, sc, lt);
      chk("held_stall", sc, 32'd33);
      do_op(32'd20, 32'd6, 1'b0, 1'b0, sc, lt);
      chk("b2b_lo", lo_o, 32'd3);
      chk("b2b_hi", hi_o, 32'd2);
      chk("b2b_lat", lt, 32'd33);

      // Randomized divides with occasional annul, checked every cycle by the model.
      for (int n = 0; n < 40; n++) begin
         int sel, annul_at;
         sel = $urandom_range(0, 9);
         case (sel)
            0:       begin a = $urandom; b = 32'd0; end
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2, 3:    begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
            4:       begin a = $urandom; b = 32'h8000_0000 | $urandom_range(0, 5); end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         signed_div = 1'($urandom_range(0, 1));
         start = 1'b1;
         annul = ($urandom_range(0, 9) == 0);
         @(posedge clk); #2;
         start = 1'b0; annul = 1'b0;
         annul_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 33)) : 0;
         for (int c = 1; c <= 35; c++) begin
            if (c == annul_at) annul = 1'b1;
            @(posedge clk); #2;
            annul = 1'b0;
         end
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
